// File: rtl/act_c2_pipe_array_if.sv
// Handshake and operand bundle for act_c2_pipe_array: operand/mode input side,
// registered result output side.
interface act_c2_pipe_array_if #(
  parameter int BITS = 4,
  parameter int CH   = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           mode;
  logic [CH*BITS-1:0]   D00;
  logic [CH*BITS-1:0]   D01;
  logic [CH*BITS-1:0]   D10;
  logic [CH*BITS-1:0]   D11;
  logic [CH-1:0]        A1;
  logic [CH-1:0]        B1;
  logic [CH-1:0]        A0;
  logic [CH-1:0]        B0;
  logic                 out_valid;
  logic                 out_ready;
  logic [CH*BITS-1:0]   out_data;
  logic [2*CH-1:0]      out_sel;

  modport master (
    output in_valid, mode, D00, D01, D10, D11, A1, B1, A0, B0, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, mode, D00, D01, D10, D11, A1, B1, A0, B0, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/act_c2_pipe_array.sv
// CH independent ACT-C2 select cells feeding a 2-stage valid/ready pipeline that
// applies LOAD / XOR-accumulate / CLEAR / HOLD to per-channel state registers.
module act_c2_pipe_array #(
  parameter int BITS = 4,
  parameter int CH   = 2
) (
  input logic            clk,
  input logic            rst_n,
  act_c2_pipe_array_if.slave bus
);

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_XACC  = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b10;

  // {S0,S1} picks one of the four data words
  function automatic logic [BITS-1:0] c2_mux(
    input logic [1:0]      sel,
    input logic [BITS-1:0] d00,
    input logic [BITS-1:0] d01,
    input logic [BITS-1:0] d10,
    input logic [BITS-1:0] d11
  );
    case (sel)
      2'b00:   c2_mux = d00;
      2'b01:   c2_mux = d01;
      2'b10:   c2_mux = d10;
      default: c2_mux = d11;
    endcase
  endfunction

  function automatic logic [BITS-1:0] apply_op(
    input logic [1:0]      op,
    input logic [BITS-1:0] st,
    input logic [BITS-1:0] m
  );
    case (op)
      MODE_LOAD:  apply_op = m;
      MODE_XACC:  apply_op = st ^ m;
      MODE_CLEAR: apply_op = '0;
      default:    apply_op = st;
    endcase
  endfunction

  logic                 s1_adv, s2_adv, load_p0, load_p1;
  logic                 vld_p0_q, vld_p1_q;
  logic [1:0]           mode_p0_q;
  logic [CH*BITS-1:0]   m_p0_d, m_p0_q;
  logic [2*CH-1:0]      sel_p0_d, sel_p0_q, sel_p1_q;
  logic [CH*BITS-1:0]   state_d, state_q;

  assign s2_adv  = !vld_p1_q || bus.out_ready;
  assign s1_adv  = !vld_p0_q || s2_adv;
  assign load_p0 = bus.in_valid && s1_adv;
  assign load_p1 = vld_p0_q && s2_adv;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = vld_p1_q;
  assign bus.out_data  = state_q;
  assign bus.out_sel   = sel_p1_q;

  always_comb begin
    logic [1:0] sel_k;
    m_p0_d   = '0;
    sel_p0_d = '0;
    sel_k    = '0;
    for (int k = 0; k < CH; k++) begin
      sel_k = {bus.A0[k] & bus.B0[k], bus.A1[k] | bus.B1[k]};
      sel_p0_d[2*k +: 2]     = sel_k;
      m_p0_d[k*BITS +: BITS] = c2_mux(sel_k,
                                      bus.D00[k*BITS +: BITS], bus.D01[k*BITS +: BITS],
                                      bus.D10[k*BITS +: BITS], bus.D11[k*BITS +: BITS]);
    end
  end

  always_comb begin
    state_d = '0;
    for (int k = 0; k < CH; k++) begin
      state_d[k*BITS +: BITS] = apply_op(mode_p0_q, state_q[k*BITS +: BITS],
                                         m_p0_q[k*BITS +: BITS]);
    end
  end

  // stage 1: capture mux result, selects and mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q  <= 1'b0;
      m_p0_q    <= '0;
      sel_p0_q  <= '0;
      mode_p0_q <= '0;
    end else begin
      if (s1_adv) vld_p0_q <= bus.in_valid;
      if (load_p0) begin
        m_p0_q    <= m_p0_d;
        sel_p0_q  <= sel_p0_d;
        mode_p0_q <= bus.mode;
      end
    end
  end

  // stage 2: apply the op to the state exactly once per transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      state_q  <= '0;
      sel_p1_q <= '0;
    end else begin
      if (s2_adv) vld_p1_q <= vld_p0_q;
      if (load_p1) begin
        state_q  <= state_d;
        sel_p1_q <= sel_p0_q;
      end
    end
  end

endmodule

// File: tb/tb_act_c2_pipe_array.sv
// Scoreboard bench for act_c2_pipe_array: directed scenarios plus randomized traffic
// against a per-channel behavioural state model.
module tb_act_c2_pipe_array;
  localparam int BITS = 4;
  localparam int CH   = 2;
  localparam logic [1:0] LOAD = 2'b00, XACC = 2'b01, CLEAR = 2'b10, HOLD = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  act_c2_pipe_array_if #(.BITS(BITS), .CH(CH)) bus ();

  act_c2_pipe_array #(.BITS(BITS), .CH(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [CH*BITS+2*CH-1:0] sbq[$];
  logic [BITS-1:0] model_st[CH];
  logic stalled = 1'b0;
  logic [CH*BITS+2*CH-1:0] held;
  logic rnd_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // reference: per channel pick Dxx by {A0&B0, A1|B1}, then apply the mode to the state
  task automatic model_accept(input logic [1:0] md,
                              input logic [CH*BITS-1:0] d00, d01, d10, d11,
                              input logic [CH-1:0] a0, b0, a1, b1);
    logic [BITS-1:0] opts[4];
    logic [BITS-1:0] m;
    logic [CH*BITS-1:0] data;
    logic [2*CH-1:0] sel;
    int idx;
    for (int k = 0; k < CH; k++) begin
      opts[0] = d00[k*BITS +: BITS];
      opts[1] = d01[k*BITS +: BITS];
      opts[2] = d10[k*BITS +: BITS];
      opts[3] = d11[k*BITS +: BITS];
      idx = 2 * int'(a0[k] & b0[k]) + int'(a1[k] | b1[k]);
      m = opts[idx];
      case (md)
        LOAD:    model_st[k] = m;
        XACC:    model_st[k] = model_st[k] ^ m;
        CLEAR:   model_st[k] = '0;
        default: model_st[k] = model_st[k];
      endcase
      data[k*BITS +: BITS] = model_st[k];
      sel[2*k +: 2] = idx[1:0];
    end
    sbq.push_back({data, sel});
  endtask

  // called aligned just after a rising edge; returns aligned after the accepting edge
  task automatic send(input logic [1:0] md,
                      input logic [CH*BITS-1:0] d00, d01, d10, d11,
                      input logic [CH-1:0] a0, b0, a1, b1);
    bool_accept: begin
      logic done;
      done = 1'b0;
      bus.mode = md; bus.D00 = d00; bus.D01 = d01; bus.D10 = d10; bus.D11 = d11;
      bus.A0 = a0; bus.B0 = b0; bus.A1 = a1; bus.B1 = b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
        @(negedge clk);
        if (bus.in_ready) begin
          model_accept(md, d00, d01, d10, d11, a0, b0, a1, b1);
          done = 1'b1;
        end
        align();
      end
      if (!done) check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_empty", sbq.size(), 0);
  endtask

  // scoreboard monitor: pops on every completed output handshake
  always @(negedge clk) begin
    logic [CH*BITS+2*CH-1:0] req;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_hold", {20'd0, bus.out_data, bus.out_sel}, {20'd0, held});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          req = sbq.pop_front();
          check("out_data", {24'd0, bus.out_data}, {24'd0, req[2*CH +: CH*BITS]});
          check("out_sel", {28'd0, bus.out_sel}, {28'd0, req[2*CH-1:0]});
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = {bus.out_data, bus.out_sel};
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic do_reset_mid();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_out_sel", {28'd0, bus.out_sel}, 32'd0);
    sbq.delete();
    for (int k = 0; k < CH; k++) model_st[k] = '0;
    align();
    align();
    #1;
    rst_n = 1'b1;
    align();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.mode = LOAD; bus.out_ready = 1'b0;
    bus.D00 = '0; bus.D01 = '0; bus.D10 = '0; bus.D11 = '0;
    bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
    for (int k = 0; k < CH; k++) model_st[k] = '0;
    #1;
    check("init_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("init_out_data", {24'd0, bus.out_data}, 32'd0);
    check("init_out_sel", {28'd0, bus.out_sel}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    align();
    check("init_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // select decode, LOAD, with latency
    bus.out_ready = 1'b1;
    send(LOAD, 8'h11, 8'h22, 8'h44, 8'h88, 2'b01, 2'b01, 2'b10, 2'b00);
    @(negedge clk);
    check("lat_early", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("lat_on", {31'd0, bus.out_valid}, 32'd1);
    #1;
    drain();
    check("decode_data", {24'd0, bus.out_data}, 32'h24);
    check("decode_sel", {28'd0, bus.out_sel}, 32'b0110);
    align();

    // XACC chain, selects 11 on both channels
    send(LOAD, 8'h00, 8'h00, 8'h00, 8'h33, 2'b11, 2'b11, 2'b11, 2'b00);
    send(XACC, 8'h00, 8'h00, 8'h00, 8'h55, 2'b11, 2'b11, 2'b11, 2'b00);
    send(XACC, 8'h00, 8'h00, 8'h00, 8'hFF, 2'b11, 2'b11, 2'b11, 2'b00);
    drain();
    check("xacc_final", {24'd0, bus.out_data}, 32'h99);
    align();

    // backpressure: two accepts then in_ready drops with the first value held
    bus.out_ready = 1'b0;
    send(LOAD, 8'h11, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00);
    send(LOAD, 8'h22, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("bp_hold", {24'd0, bus.out_data}, 32'h11);
    align();
    fork
      begin
        send(LOAD, 8'h33, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00);
        send(LOAD, 8'h44, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00);
      end
      begin
        repeat (3) align();
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_last", {24'd0, bus.out_data}, 32'h44);
    align();

    // HOLD keeps state, CLEAR zeroes it
    send(LOAD, 8'h00, 8'h00, 8'h00, 8'hAA, 2'b11, 2'b11, 2'b11, 2'b11);
    send(HOLD, 8'h55, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00);
    drain();
    check("hold_data", {24'd0, bus.out_data}, 32'hAA);
    check("hold_sel", {28'd0, bus.out_sel}, 32'b0000);
    align();
    send(CLEAR, 8'h00, 8'h77, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 2'b10);
    drain();
    check("clear_data", {24'd0, bus.out_data}, 32'h00);
    check("clear_sel", {28'd0, bus.out_sel}, 32'b0101);
    align();

    // reset with both stages full and output stalled
    bus.out_ready = 1'b0;
    send(LOAD, 8'h00, 8'h00, 8'h00, 8'hCC, 2'b11, 2'b11, 2'b11, 2'b11);
    send(LOAD, 8'h00, 8'h00, 8'h00, 8'hDD, 2'b11, 2'b11, 2'b11, 2'b11);
    do_reset_mid();
    bus.out_ready = 1'b1;
    send(XACC, 8'h00, 8'h00, 8'h00, 8'h77, 2'b11, 2'b11, 2'b11, 2'b11);
    drain();
    check("post_rst_xacc", {24'd0, bus.out_data}, 32'h77);
    align();

    // randomized traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int n = 0; n < 200; n++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) align();
    end
    rnd_rdy = 1'b0;
    align();
    align();
    bus.out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/act_c2_pipe_array.md
Name: act_c2_pipe_array

Overview:
- Parametrised, pipelined successor of the single ACT-C2 combinational logic cell.
- Instantiates CH independent BITS-wide C2 cells:
  - S0 = A0 & B0, S1 = A1 | B1.
  - Data select: {S0,S1} = 00→D00, 01→D01, 10→D10, 11→D11.
- Adds a 2-stage registered datapath with a valid/ready handshake.
- Adds a per-channel state register with load/xor-accumulate/clear modes. Sits between operand sources and downstream logic in the CAD logic-module fabric.

Parameters:
- BITS, 4, data width per channel.
- CH, 2, number of independent C2 channels.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block accepts input this cycle.
- mode  input  2  00 LOAD, 01 XACC (state ^= mux), 10 CLEAR, 11 HOLD; sampled with the transaction.
- D00, D01, D10, D11  input  CH*BITS each  packed per channel; channel k = bits [k*BITS +: BITS].
- A1, B1, A0, B0  input  CH each  per-channel select terms; channel k = bit k.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  CH*BITS  per-channel state registers.
- out_sel  output  2*CH  registered {S0,S1} of the delivered transaction; channel k = bits [2k+1:2k], S0 in the upper bit.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - s1_valid = 0, s2_valid = 0, out_valid = 0.
  - out_data = 0, out_sel = 0, all state registers = 0.
  - in_ready = 1 once reset is released.
  - Reset mid-transaction discards all in-flight data; no partial output appears.
- Stage 1 (capture):
  - On in_valid & in_ready, register per-channel mux result m[k], {S0,S1}[k], and mode. Set s1_valid = 1.
  - The mux is fully decoded: output is never X/Z for defined selects.
- Stage 2 (apply):
  - When s1_valid and stage 2 advances, per channel:
    - LOAD: state = m.
    - XACC: state = state ^ m.
    - CLEAR: state = 0.
    - HOLD: state unchanged.
  - out_sel updates to the stage-1 {S0,S1} in all modes. Set s2_valid = 1.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no combinational path from in_valid).
  - out_valid = s2_valid.
  - If out_valid & out_ready and no new stage-2 load, s2_valid clears.
- Latency and throughput:
  - Latency is 2 cycles: a transaction accepted at edge N appears on out_data after edge N+1, with out_valid high.
  - Throughput is 1 transaction/cycle while out_ready is held high.
- Backpressure:
  - out_ready low holds out_data/out_sel/out_valid stable.
  - Stage 1 still fills if empty. in_ready drops only when both stages are full.
  - No transaction is lost or duplicated.
- XACC ordering: the state chain follows acceptance order exactly. Stalls never re-apply an op.
- Channels are fully independent. All share one handshake and one mode.
- Simultaneous events:
  - Output consume and new stage-2 load in the same cycle: load wins, out_valid stays 1.
  - Input accept with stage 1 advancing in the same cycle: stage 1 takes the new transaction.
- Width rule: XOR/selection are bitwise at BITS. No carries, no truncation.

Test Plan:
- Reset state: CH=2, BITS=4; assert rst_n=0 mid-stream → out_valid=0, out_data=0x00, out_sel=0 immediately; after release, in_ready=1.
- Select decode, LOAD mode, out_ready=1:
  - D00=1, D01=2, D10=4, D11=8 per channel.
  - ch0 A0=B0=1, A1=B1=0 → 0x4, out_sel[1:0]=2'b10.
  - ch1 A0=0, A1=1 → 0x2, out_sel[3:2]=2'b01.
  - Result: out_data=0x24, out_valid exactly 2 cycles after accept.
- XACC chain on ch0, selects fixed to 11:
  - Sequence D11 = 0x3, 0x5, 0xF with modes LOAD, XACC, XACC.
  - ch0 outputs in order: 0x3, 0x6, 0x9.
- Backpressure: stream 4 LOAD transactions with values 1,2,3,4; hold out_ready=0 for 5 cycles.
  - in_ready falls after 2 accepts; out_data holds 1.
  - After release, outputs 1,2,3,4 appear in order with no gaps while out_ready=1.
- CLEAR/HOLD:
  - state 0xA; send HOLD with m=0x5 → 0xA.
  - Then CLEAR → 0x0.
  - out_sel tracks each transaction's selects.
- Reset mid-operation: assert rst_n low with both stages full and out_ready=0 → all valids clear; post-reset XACC of 0x7 yields 0x7 (state was zeroed).
